timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// Prescaled up-counter timer with a START/STOP/PAUSE/RESUME command handshake.
// It can run one-shot or periodic, and it raises a registered expire pulse on each terminal count.
module timer_ctrl #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [COUNTER_WIDTH-1:0]  cmd_period,
  input  logic [PRESCALE_WIDTH-1:0] cmd_prescale,
  input  logic                      cmd_oneshot,
  output logic [COUNTER_WIDTH-1:0]  count,
  output logic                      expire,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  state_t                    r_state;
  logic [COUNTER_WIDTH-1:0]  r_count;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [COUNTER_WIDTH-1:0]  r_period;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_oneshot;
  logic                      r_expire;
  logic                      r_busy;
  logic                      r_done;

  state_t                    w_state_nxt;
  logic [COUNTER_WIDTH-1:0]  w_count_nxt;
  logic [PRESCALE_WIDTH-1:0] w_presc_nxt;
  logic [COUNTER_WIDTH-1:0]  w_period_nxt;
  logic [PRESCALE_WIDTH-1:0] w_prescale_nxt;
  logic                      w_oneshot_nxt;
  logic                      w_expire_nxt;
  logic                      w_done_nxt;
  logic                      w_ready;
  logic                      w_accept;
  logic                      w_tick;

  assign w_ready  = (r_state != S_LOAD);
  assign w_accept = cmd_valid && w_ready;
  assign w_tick   = (r_state == S_RUN) && (r_presc == r_prescale);

  assign cmd_ready = w_ready;
  assign count     = r_count;
  assign expire    = r_expire;
  assign busy      = r_busy;
  assign done      = r_done;

  // Next-state logic: an accepted START/STOP overrides the tick in that cycle.
  // expire is registered, so it reports the terminal tick taken at the preceding edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_presc_nxt    = r_presc;
    w_period_nxt   = r_period;
    w_prescale_nxt = r_prescale;
    w_oneshot_nxt  = r_oneshot;
    w_expire_nxt   = 1'b0;
    w_done_nxt     = r_done;
    if (w_accept && (cmd_op == OP_START)) begin
      w_state_nxt    = S_LOAD;
      w_period_nxt   = cmd_period;
      w_prescale_nxt = cmd_prescale;
      w_oneshot_nxt  = cmd_oneshot;
      w_count_nxt    = '0;
      w_presc_nxt    = '0;
      w_done_nxt     = 1'b0;
    end else if (w_accept && (cmd_op == OP_STOP)) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_LOAD: begin
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_accept && (cmd_op == OP_PAUSE)) begin
            w_state_nxt = S_PAUSE;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            if (r_count == r_period) begin
              w_expire_nxt = 1'b1;
              if (r_oneshot) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end else begin
                w_count_nxt = '0;
              end
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_accept && (cmd_op == OP_RESUME)) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_PAUSE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_presc    <= '0;
      r_period   <= '0;
      r_prescale <= '0;
      r_oneshot  <= 1'b0;
      r_expire   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_presc    <= w_presc_nxt;
      r_period   <= w_period_nxt;
      r_prescale <= w_prescale_nxt;
      r_oneshot  <= w_oneshot_nxt;
      r_expire   <= w_expire_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

endmodule
